// File: rtl/array_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : array_ctrl
// Purpose  : Flow controller for an externally built ROWS x COLS systolic
//            array. Tracks which array rows hold live beats with a shadow
//            valid shift register, drives the array enable/reset/set strobes,
//            inserts bubbles when no beat is offered, and presents the array
//            bottom row as a valid/ready downstream stream. Also executes
//            clear/preset commands and a level-sensitive flush.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   ROWS  array depth (stages per column)
//   COLS  array width (columns)
//   CW    delivered-beat counter width
// Ports
//   clock, reset            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready       upstream handshake
//   in_a, in_b              in-path / ou-path column data
//   clr_req, set_req        array clear / ou-path preset requests
//   flush                   level: drain the array with bubbles
//   cmd_ack, flush_done     one-cycle completion pulses
//   arr_enable              array shift enable
//   arr_reset, arr_set      array clear / ou-path preset strobes
//   arr_in, arr_ou          data into the array top row
//   arr_bot_in, arr_bot_ou  data out of the array bottom row
//   out_valid/out_ready     downstream handshake
//   out_a, out_b            downstream data (bottom row, combinational)
//   beat_cnt                beats delivered downstream (wraps)
//   occupancy               live beats currently inside the array
// ============================================================================
module array_ctrl #(
  parameter int ROWS = 5,
  parameter int COLS = 5,
  parameter int CW   = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  // upstream
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [COLS-1:0]             in_a,
  input  logic [COLS-1:0]             in_b,
  // commands
  input  logic                        clr_req,
  input  logic                        set_req,
  input  logic                        flush,
  output logic                        cmd_ack,
  output logic                        flush_done,
  // array side
  output logic                        arr_enable,
  output logic                        arr_reset,
  output logic                        arr_set,
  output logic [COLS-1:0]             arr_in,
  output logic [COLS-1:0]             arr_ou,
  input  logic [COLS-1:0]             arr_bot_in,
  input  logic [COLS-1:0]             arr_bot_ou,
  // downstream
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [COLS-1:0]             out_a,
  output logic [COLS-1:0]             out_b,
  output logic [CW-1:0]               beat_cnt,
  output logic [$clog2(ROWS+1)-1:0]   occupancy
);

  localparam int OW = $clog2(ROWS+1);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    CLR        = 2'd1,
    SET        = 2'd2,
    FLUSH_WAIT = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t          r_state;
  logic [ROWS:1]   r_vld;          // r_vld[ROWS] mirrors the array bottom row
  logic [OW-1:0]   r_occ;
  logic [CW-1:0]   r_beat_cnt;
  logic            r_cmd_ack;
  logic            r_arr_set;
  logic            r_arr_clr;
  logic            r_flush_done;

  // --------------------------------------------------------------------------
  // Combinational flow control
  // --------------------------------------------------------------------------
  logic            w_run;
  logic            w_room;
  logic            w_any_vld;
  logic            w_adv;
  logic            w_accept;
  logic            w_pop;
  logic [OW-1:0]   w_occ_next;
  logic [ROWS:1]   w_vld_shifted;

  assign w_run     = (r_state == RUN);
  // The bottom row is free if it is empty or is being taken this cycle.
  assign w_room    = !r_vld[ROWS] || out_ready;
  assign w_any_vld = |r_vld;
  // Only shift when something could move; an idle empty array stays put.
  assign w_adv     = w_room && w_run && (in_valid || flush || w_any_vld);

  assign in_ready  = w_run && !flush && w_room;
  assign w_accept  = in_valid && in_ready;

  // out_valid is qualified with RUN: in CLR/SET the array is frozen, so a
  // handshake there would deliver the bottom beat without retiring it.
  assign out_valid = r_vld[ROWS] && w_run;
  assign w_pop     = out_valid && out_ready;
  assign out_a     = arr_bot_in;
  assign out_b     = arr_bot_ou;

  // Bubbles are driven as zeros so that idle slots carry no stale data.
  assign arr_in     = w_accept ? in_a : '0;
  assign arr_ou     = w_accept ? in_b : '0;
  assign arr_enable = w_adv;

  // The array ou-path has no reset of its own, so it follows the controller
  // reset as well as the CLR command.
  assign arr_reset  = reset || r_arr_clr;
  assign arr_set    = r_arr_set;
  assign cmd_ack    = r_cmd_ack;
  assign flush_done = r_flush_done;
  assign beat_cnt   = r_beat_cnt;
  assign occupancy  = r_occ;

  always_comb begin
    w_occ_next = r_occ;
    case ({w_accept, w_pop})
      2'b10:   w_occ_next = r_occ + OW'(1);
      2'b01:   w_occ_next = r_occ - OW'(1);
      default: w_occ_next = r_occ;
    endcase
  end

  // Shadow register shift: the new top entry is the accept flag, so bubbles
  // enter as 0 and can never reach the bottom as a valid beat.
  generate
    if (ROWS == 1) begin : g_shift_single
      assign w_vld_shifted = w_accept;
    end else begin : g_shift_multi
      assign w_vld_shifted = {r_vld[ROWS-1:1], w_accept};
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Controller FSM with registered command outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= RUN;
      r_vld        <= '0;
      r_occ        <= '0;
      r_beat_cnt   <= '0;
      r_cmd_ack    <= 1'b0;
      r_arr_set    <= 1'b0;
      r_arr_clr    <= 1'b0;
      r_flush_done <= 1'b0;
    end else begin
      r_cmd_ack    <= 1'b0;
      r_arr_set    <= 1'b0;
      r_arr_clr    <= 1'b0;
      r_flush_done <= 1'b0;

      // Not cleared by CLR: it counts deliveries over the whole session.
      if (w_pop) begin
        r_beat_cnt <= r_beat_cnt + CW'(1);
      end

      case (r_state)
        RUN: begin
          if (w_adv) begin
            r_vld <= w_vld_shifted;
          end
          r_occ <= w_occ_next;
          // Commands have priority over flush; clear wins over preset.
          if (clr_req) begin
            r_state   <= CLR;
            r_arr_clr <= 1'b1;
            r_cmd_ack <= 1'b1;
          end else if (set_req) begin
            r_state   <= SET;
            r_arr_set <= 1'b1;
            r_cmd_ack <= 1'b1;
          end else if (flush && (w_occ_next == '0)) begin
            r_state      <= FLUSH_WAIT;
            r_flush_done <= 1'b1;
          end
        end

        CLR: begin
          r_vld   <= '0;
          r_occ   <= '0;
          r_state <= RUN;
        end

        SET: begin
          r_state <= RUN;
        end

        FLUSH_WAIT: begin
          if (!flush) begin
            r_state <= RUN;
          end
        end

        default: begin
          r_state <= RUN;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/array_ctrl.md
ARRAY_CTRL -- requirements
Module: array_ctrl

Interface
REQ-001 Parameters SHALL be: ROWS 5 (array depth, stages per column); COLS 5 (array width, columns); CW 16 (beat-counter width).
REQ-002 Ports SHALL be: clock in 1 (rising-edge clock); reset in 1 (synchronous, active-high reset, clock clock).
REQ-003 Upstream ports SHALL be: in_valid in 1 (input beat offered); in_ready out 1 (beat accepted when in_valid&&in_ready); in_a in COLS (in-path column data); in_b in COLS (ou-path column data).
REQ-004 Command ports SHALL be: clr_req in 1 (request array clear); set_req in 1 (request ou-path preset to 1); flush in 1 (level, drain array with bubbles); cmd_ack out 1 (one-cycle pulse, command executed); flush_done out 1 (one-cycle pulse, array empty after flush).
REQ-005 Array-side ports SHALL be: arr_enable out 1; arr_reset out 1; arr_set out 1; arr_in out COLS (to in_00_c); arr_ou out COLS (to ou_00_(c-1)); arr_bot_in in COLS (from in_ROWS_c); arr_bot_ou in COLS (from ou_ROWS_c).
REQ-006 Downstream ports SHALL be: out_valid out 1; out_ready in 1; out_a out COLS; out_b out COLS; beat_cnt out CW (beats delivered); occupancy out clog2(ROWS+1) (valid beats inside array).

Function
REQ-007 The block SHALL track beat validity with a ROWS-deep shadow shift register vld[1..ROWS], vld[ROWS] corresponding to the array bottom row.
REQ-008 out_valid SHALL equal vld[ROWS]; out_a/out_b SHALL equal arr_bot_in/arr_bot_ou combinationally.
REQ-009 Advance condition: adv = (!vld[ROWS] || out_ready) && state==RUN && (in_valid || flush || any vld set).
REQ-010 arr_enable SHALL equal adv; on adv the shadow shifts, vld[1] <= (in_valid && !flush).
REQ-011 in_ready SHALL equal state==RUN && !flush && (!vld[ROWS] || out_ready).
REQ-012 arr_in/arr_ou SHALL equal in_a/in_b when in_valid && in_ready, else all zeros (bubble).
REQ-013 Latency: a beat accepted at edge N SHALL appear with out_valid high after edge N+ROWS-1 given no stall; throughput one beat per cycle.
REQ-014 Stall: while out_valid && !out_ready, arr_enable SHALL be 0, out_a/out_b held, no beat lost or duplicated.
REQ-015 FSM states SHALL be RUN, CLR, SET, FLUSH_WAIT.
REQ-016 RUN->CLR on clr_req; RUN->SET on set_req && !clr_req; clr_req SHALL win when both are high.
REQ-017 CLR: one cycle, arr_reset=1, arr_enable=0, all vld cleared, occupancy 0, cmd_ack=1, then RUN.
REQ-018 SET: one cycle, arr_set=1, arr_enable=0, vld unchanged, cmd_ack=1, then RUN.
REQ-019 Commands SHALL only be sampled in RUN; requests while not in RUN SHALL be ignored (requester holds until cmd_ack).
REQ-020 RUN with flush && occupancy!=0 SHALL keep advancing with bubbles; when occupancy reaches 0 SHALL go FLUSH_WAIT, pulse flush_done, and stay until flush deasserts, then RUN.
REQ-021 flush asserted with occupancy already 0 SHALL pulse flush_done the next cycle.
REQ-022 occupancy SHALL be the popcount of vld, updated every cycle: +1 on accept, -1 on out_valid&&out_ready, unchanged if both.
REQ-023 beat_cnt SHALL increment on each out_valid&&out_ready, wrap from 2^CW-1 to 0, and not be cleared by CLR.
REQ-024 Bubbles SHALL never raise out_valid.

Reset
REQ-025 On reset: state RUN, vld all 0, occupancy 0, beat_cnt 0, in_ready 1, out_valid 0, cmd_ack 0, flush_done 0, arr_enable 0, arr_set 0.
REQ-026 arr_reset SHALL be 1 while reset is high so the array ou-path clears together with the controller.
REQ-027 Reset mid-operation SHALL discard all in-flight beats without emitting them.

Verification
REQ-028 Reset, 5 back-to-back beats in_a=1..5, out_ready=1 -> out_valid first high 4 edges after first accept; out_a sequence 1..5; beat_cnt=5.
REQ-029 Fill 5 beats, out_ready=0 for 10 cycles -> in_ready=0, arr_enable=0, occupancy=5, out_a stable; release -> 5 beats in order, none lost.
REQ-030 3 beats accepted, flush=1 -> bubbles inserted, 3 beats out, flush_done single pulse when occupancy=0, in_ready=0 throughout flush.
REQ-031 clr_req and set_req high same cycle with occupancy=3 -> arr_reset pulse, cmd_ack pulse, occupancy=0, no further out_valid; set serviced after re-request.
REQ-032 beat_cnt preset path: stream 2^CW+2 beats (CW=4 build) -> beat_cnt wraps to 2.
REQ-033 Reset asserted with occupancy=4 -> next cycle out_valid=0, occupancy=0, arr_reset=1 during reset.
